// File: rtl/dii_arb_pkg.sv
// Shared types and helpers for the DII packet arbiter.
//   arb_state_e  : arbiter state (idle pick / packet in progress)
//   arb_next_ptr : round-robin pointer advance with explicit wrap, so that
//                  non-power-of-2 port counts rotate correctly.
package dii_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned arb_next_ptr(input int unsigned idx,
                                                 input int unsigned ports);
        return (idx == ports - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dii_rr_select.sv
// Combinational round-robin selector.
//   req     : request vector, one bit per port
//   ptr     : highest-priority port index (0..PORTS-1)
//   gnt     : one-hot grant, 0 when no request
//   gnt_idx : index of the granted port (0 when no request)
// Scans ptr, ptr+1, ... wrapping from PORTS-1 back to 0.
module dii_rr_select #(
    parameter int PORTS = 2,
    parameter int PTR_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PORTS-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    // Candidate port for each scan offset. One extra bit holds ptr+offset
    // before the wrap, which never exceeds 2*PORTS-2.
    logic [PTR_W-1:0] cand_idx [PORTS];

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_cand
            logic [PTR_W:0] sum_w;
            assign sum_w = {1'b0, ptr} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum_w > (PTR_W+1)'(PORTS - 1))
                                ? PTR_W'(sum_w - (PTR_W+1)'(PORTS))
                                : PTR_W'(sum_w);
        end
    endgenerate

    always_comb begin
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            if (!found && req[cand_idx[k]]) begin
                found              = 1'b1;
                gnt_idx            = cand_idx[k];
                gnt[cand_idx[k]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one DII channel between
// PORTS sources. The output path is purely combinational; only the state,
// locked port, priority pointer and sticky error flag are registered.
//   clk, rst        : clock, synchronous active-high reset
//   in_data         : port p flit at [p*WIDTH +: WIDTH]
//   in_first/last   : per-port framing markers
//   in_valid/ready  : per-port handshake (ready only to the granted port)
//   out_*           : selected flit and handshake
//   grant           : one-hot port currently driving the output, 0 if none
//   locked          : a multi-flit packet is in progress
//   protocol_error  : sticky framing violation flag, cleared by rst only
module dii_packet_arbiter
    import dii_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PORTS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS*WIDTH-1:0] in_data,
    input  logic [PORTS-1:0]       in_first,
    input  logic [PORTS-1:0]       in_last,
    input  logic [PORTS-1:0]       in_valid,
    output logic [PORTS-1:0]       in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PORTS-1:0]       grant,
    output logic                   locked,
    output logic                   protocol_error
);

    localparam int PTR_W = $clog2(PORTS);

    arb_state_e       state_reg, state_next;
    logic [PTR_W-1:0] prio_ptr_reg, prio_ptr_next;
    logic [PTR_W-1:0] lock_port_reg, lock_port_next;
    logic             protocol_error_reg, protocol_error_next;

    logic [PORTS-1:0] rr_gnt;
    logic [PTR_W-1:0] rr_idx;
    logic [PORTS-1:0] lock_onehot;
    logic [PTR_W-1:0] sel_idx;
    logic             xfer;

    dii_rr_select #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req     (in_valid),
        .ptr     (prio_ptr_reg),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            assign lock_onehot[gi] = (lock_port_reg == PTR_W'(gi));
            assign in_ready[gi]    = out_ready & grant[gi];
        end
    endgenerate

    // Grant source: live round-robin pick when idle, held port when locked.
    // Forced to zero during reset so nothing is accepted.
    always_comb begin
        grant   = '0;
        sel_idx = rr_idx;
        if (!rst) begin
            if (state_reg == ARB_LOCKED) begin
                grant   = lock_onehot;
                sel_idx = lock_port_reg;
            end else begin
                grant   = rr_gnt;
            end
        end
    end

    always_comb begin
        out_data  = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_valid = 1'b0;
        if (|grant) begin
            out_data  = in_data[32'(sel_idx) * WIDTH +: WIDTH];
            out_first = in_first[sel_idx];
            out_last  = in_last[sel_idx];
            out_valid = in_valid[sel_idx];
        end
    end

    assign xfer           = out_valid & out_ready;
    assign locked         = !rst && (state_reg == ARB_LOCKED);
    assign protocol_error = protocol_error_reg;

    always_comb begin
        state_next          = state_reg;
        prio_ptr_next       = prio_ptr_reg;
        lock_port_next      = lock_port_reg;
        protocol_error_next = protocol_error_reg;
        if (xfer) begin
            if (state_reg == ARB_IDLE) begin
                if (!out_first) protocol_error_next = 1'b1;
                if (out_last) begin
                    prio_ptr_next = PTR_W'(arb_next_ptr(32'(sel_idx), PORTS));
                end else begin
                    state_next     = ARB_LOCKED;
                    lock_port_next = sel_idx;
                end
            end else begin
                if (out_first) protocol_error_next = 1'b1;
                if (out_last) begin
                    state_next    = ARB_IDLE;
                    prio_ptr_next = PTR_W'(arb_next_ptr(32'(lock_port_reg), PORTS));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ARB_IDLE;
            prio_ptr_reg       <= '0;
            lock_port_reg      <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            prio_ptr_reg       <= prio_ptr_next;
            lock_port_reg      <= lock_port_next;
            protocol_error_reg <= protocol_error_next;
        end
    end

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Randomized bench for dii_packet_arbiter (PORTS=3, non-power-of-2 wrap).
// A reference model tracks packet ownership, the next-priority port and the
// sticky error flag with plain integers and checks every output each cycle.
module tb_dii_packet_arbiter;

    localparam int W = 16;
    localparam int P = 3;

    logic           clk = 1'b0;
    logic           drv_rst;
    logic [P*W-1:0] drv_data;
    logic [P-1:0]   drv_first, drv_last, drv_valid;
    logic           drv_ready;

    logic [P-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_first, out_last, out_valid;
    logic [P-1:0]   grant;
    logic           locked, protocol_error;

    always #5 clk = ~clk;

    dii_packet_arbiter #(.WIDTH(W), .PORTS(P)) dut (
        .clk            (clk),
        .rst            (drv_rst),
        .in_data        (drv_data),
        .in_first       (drv_first),
        .in_last        (drv_last),
        .in_valid       (drv_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_first      (out_first),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (drv_ready),
        .grant          (grant),
        .locked         (locked),
        .protocol_error (protocol_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    bit m_known  = 0;   // becomes 1 after the first reset edge
    bit m_in_pkt = 0;
    int m_owner  = 0;
    int m_prio   = 0;
    bit m_err    = 0;
    int acc_port;       // port whose flit was accepted this cycle, -1 if none

    task automatic check_cycle();
        bit           has;
        int           g;
        logic [P-1:0] e_grant;
        logic [W-1:0] e_data;
        bit           e_valid, e_first, e_last, xf;
        has = 0; g = 0;
        if (!drv_rst) begin
            if (m_in_pkt) begin
                has = 1; g = m_owner;
            end else begin
                for (int k = 0; k < P; k++) begin
                    if (!has && drv_valid[(m_prio + k) % P]) begin
                        has = 1; g = (m_prio + k) % P;
                    end
                end
            end
        end
        e_grant = has ? P'(1 << g) : '0;
        e_data  = has ? drv_data[g*W +: W] : '0;
        e_valid = has && drv_valid[g];
        e_first = has && drv_first[g];
        e_last  = has && drv_last[g];

        check_eq("grant",     32'(grant),     32'(e_grant));
        check_eq("in_ready",  32'(in_ready),  32'(drv_ready ? e_grant : '0));
        check_eq("out_valid", 32'(out_valid), 32'(e_valid));
        check_eq("out_data",  32'(out_data),  32'(e_data));
        check_eq("out_first", 32'(out_first), 32'(e_first));
        check_eq("out_last",  32'(out_last),  32'(e_last));
        check_eq("locked",    32'(locked),    32'(!drv_rst && m_in_pkt));
        if (m_known) check_eq("protocol_error", 32'(protocol_error), 32'(m_err));

        $display("cyc t=%0t rst=%0b v=%b rdy=%0b grant=%b data=%h f=%0b l=%0b locked=%0b err=%0b",
                 $time, drv_rst, drv_valid, drv_ready, grant, out_data, out_first, out_last,
                 locked, protocol_error);

        xf = e_valid && drv_ready;
        acc_port = xf ? g : -1;
        if (drv_rst) begin
            m_known = 1; m_in_pkt = 0; m_prio = 0; m_err = 0;
        end else if (xf) begin
            if (!m_in_pkt) begin
                if (!e_first) m_err = 1;
                if (e_last) m_prio = (g + 1) % P;
                else begin m_in_pkt = 1; m_owner = g; end
            end else begin
                if (e_first) m_err = 1;
                if (e_last) begin m_in_pkt = 0; m_prio = (m_owner + 1) % P; end
            end
        end
    endtask

    int dcount = 0;
    task automatic dcycle(input logic [P-1:0] v, input logic [P-1:0] f, input logic [P-1:0] l,
                          input logic r, input logic rs);
        @(posedge clk); #1;
        drv_valid = v; drv_first = f; drv_last = l; drv_ready = r; drv_rst = rs;
        for (int p = 0; p < P; p++) drv_data[p*W +: W] = W'(16'hA000 + p * 256 + dcount);
        dcount++;
        #3;
        check_cycle();
    endtask

    // Random packet sources
    int         s_rem  [P];
    int         s_pos  [P];
    bit         s_hold [P];
    bit         s_f    [P];
    bit         s_l    [P];
    logic [W-1:0] s_d  [P];
    int         s_seq  [P];

    task automatic rcycle(input int ready_pct, input int rst_per);
        @(posedge clk); #1;
        for (int p = 0; p < P; p++) begin
            if (!s_hold[p]) begin
                if (s_rem[p] == 0 && $urandom_range(0, 3) != 0) begin
                    s_rem[p] = $urandom_range(1, 4); s_pos[p] = 0;
                end
                if (s_rem[p] > 0 && $urandom_range(0, 5) != 0) begin
                    s_hold[p] = 1;
                    s_f[p] = (s_pos[p] == 0);
                    s_l[p] = (s_rem[p] == 1);
                    if ($urandom_range(0, 79) == 0) s_f[p] = !s_f[p];
                    s_d[p] = W'((p << 12) | (s_seq[p] & 12'hfff));
                    s_seq[p]++;
                end
            end
            drv_valid[p] = s_hold[p] && ($urandom_range(0, 7) != 0);
            drv_first[p] = s_f[p];
            drv_last[p]  = s_l[p];
            drv_data[p*W +: W] = s_d[p];
        end
        drv_ready = ($urandom_range(0, 99) < ready_pct);
        drv_rst   = ($urandom_range(0, rst_per - 1) == 0);
        #3;
        check_cycle();
        if (drv_rst) begin
            for (int p = 0; p < P; p++) begin s_hold[p] = 0; s_rem[p] = 0; end
        end else if (acc_port >= 0) begin
            s_hold[acc_port] = 0;
            s_pos[acc_port]++;
            s_rem[acc_port]--;
        end
    endtask

    initial begin
        drv_rst = 1'b1; drv_data = '0; drv_first = '0; drv_last = '0;
        drv_valid = '0; drv_ready = 1'b0;
        for (int p = 0; p < P; p++) begin
            s_rem[p] = 0; s_pos[p] = 0; s_hold[p] = 0; s_seq[p] = 0;
            s_f[p] = 0; s_l[p] = 0; s_d[p] = '0;
        end

        // Reset state
        dcycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
        dcycle(3'b111, 3'b111, 3'b000, 1'b1, 1'b1);
        // Three-flit packet on port 0
        dcycle(3'b001, 3'b001, 3'b000, 1'b1, 1'b0);
        dcycle(3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
        dcycle(3'b001, 3'b000, 3'b001, 1'b1, 1'b0);
        // Port 1 holds priority; out_ready low then high
        dcycle(3'b011, 3'b011, 3'b011, 1'b0, 1'b0);
        dcycle(3'b011, 3'b011, 3'b011, 1'b0, 1'b0);
        dcycle(3'b011, 3'b011, 3'b011, 1'b1, 1'b0);
        // Flit with first=0 in idle on port 2 -> sticky error
        dcycle(3'b100, 3'b000, 3'b100, 1'b1, 1'b0);
        dcycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        // Port 0 locks, bubble while others valid, then reset mid-packet
        dcycle(3'b001, 3'b001, 3'b000, 1'b1, 1'b0);
        dcycle(3'b110, 3'b110, 3'b110, 1'b1, 1'b0);
        dcycle(3'b111, 3'b000, 3'b000, 1'b1, 1'b1);
        dcycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);

        // Randomized phases: full throughput, back-pressure, heavy back-pressure
        for (int i = 0; i < 1500; i++) rcycle(100, 400);
        for (int i = 0; i < 1500; i++) rcycle(70, 250);
        for (int i = 0; i < 1000; i++) rcycle(25, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
